fifo_reader: RTL



---
 rtl/fifo_reader_if.sv | 25 ++
 rtl/fifo_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader_if.sv
// Handshake bundle for fifo_reader: block-side FIFO read port plus the word output stream.
// master = the reader, slave = the blocks and the word consumer.
interface fifo_reader_if #(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  parameter int unsigned WORD_W     = 36
);
  logic [NUM_BLOCKS-1:0] fifo_empty;
  logic [NUM_BLOCKS-1:0] fifo_bit;
  logic [NUM_BLOCKS-1:0] fifo_req;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_W-1:0]     out_word;
  logic [IDX_W-1:0]      out_idx;

  modport master (
    input  fifo_empty, fifo_bit, out_ready,
    output fifo_req, out_valid, out_word, out_idx
  );

  modport slave (
    output fifo_empty, fifo_bit, out_ready,
    input  fifo_req, out_valid, out_word, out_idx
  );
endinterface

// File: rtl/fifo_reader.sv
// Round-robin collector of serial result words from NUM_BLOCKS block FIFOs (fifo_clk domain).
// Optional guard-bit / header check enabled by FIFO_READER_FRAME_CHECK_EN.
module fifo_reader #(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  parameter int unsigned WORD_W     = 36
) (
  input  logic            fifo_clk,
  input  logic            fifo_rst,
  input  logic            enable,
  fifo_reader_if.master   bus,
  output logic            busy
`ifdef FIFO_READER_FRAME_CHECK_EN
  ,
  output logic            frame_err
`endif
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
`ifdef FIFO_READER_FRAME_CHECK_EN
  // One extra SHIFT cycle samples the guard bit after the last data bit.
  localparam logic [CNT_W-1:0] EndCnt = CNT_W'(WORD_W);
`else
  localparam logic [CNT_W-1:0] EndCnt = CNT_W'(WORD_W - 1);
`endif

  typedef enum logic [2:0] {StIdle, StReq, StWait, StShift, StHold} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_W-1:0]     sh_q, sh_d;
  logic [NUM_BLOCKS-1:0] req_q, req_d;
  logic                  valid_q, valid_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ferr_q, ferr_d;

  logic [IDX_W-1:0]      pick;
  logic                  pick_found;
  logic                  sel_bit;
  logic                  slot_free;
  logic                  done;
  logic                  load;
  logic [WORD_W-1:0]     load_word;

  assign sel_bit   = bus.fifo_bit[sel_q];
  assign slot_free = !valid_q || bus.out_ready;

  // First non-empty block scanning upward from the round-robin pointer.
  always_comb begin
    int unsigned      j;
    logic [IDX_W-1:0] jj;
    pick       = '0;
    pick_found = 1'b0;
    j          = 0;
    jj         = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      j  = (32'(rr_q) + i) % NUM_BLOCKS;
      jj = j[IDX_W-1:0];
      if (!pick_found && !bus.fifo_empty[jj]) begin
        pick_found = 1'b1;
        pick       = jj;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    req_d     = '0;
    valid_d   = valid_q;
    word_d    = word_q;
    idx_d     = idx_q;
    ferr_d    = ferr_q;
    done      = 1'b0;
    load      = 1'b0;
    load_word = sh_q;

    if (valid_q && bus.out_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && pick_found) begin
          sel_d   = pick;
          req_d   = NUM_BLOCKS'(1) << pick;
          state_d = StReq;
        end
      end
      StReq: begin
        rr_d    = (sel_q == IDX_W'(NUM_BLOCKS - 1)) ? '0 : sel_q + 1'b1;
        state_d = StWait;
      end
      StWait: begin
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
`ifdef FIFO_READER_FRAME_CHECK_EN
        if (cnt_q == EndCnt) begin
          done   = 1'b1;
          ferr_d = ferr_q | sel_bit | (|sh_q[WORD_W-1 -: 4]);
        end else begin
          sh_d = {sel_bit, sh_q[WORD_W-1:1]};
        end
`else
        // LSB-first: after WORD_W shifts the first received bit sits at bit 0.
        sh_d      = {sel_bit, sh_q[WORD_W-1:1]};
        load_word = sh_d;
        done      = (cnt_q == EndCnt);
`endif
        if (done) begin
          if (slot_free) begin
            load    = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new load wins over the clear from an accepted word on the same edge.
    if (load) begin
      valid_d = 1'b1;
      word_d  = load_word;
      idx_d   = sel_q;
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.fifo_req  = req_q;
  assign bus.out_valid = valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_idx   = idx_q;
  assign busy          = (state_q != StIdle);

`ifdef FIFO_READER_FRAME_CHECK_EN
  assign frame_err = ferr_q;
`else
  logic unused_ferr;
  assign unused_ferr = ferr_q ^ ferr_d;
`endif

endmodule
